// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-organised data memory.
// Sub-word stores at non-zero offsets use a read-modify-write sequence; sub-word loads are aligned and extended here.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter bit RMW_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_rr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_w_mask,
  output logic [3:0]        mem_r_mask,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD, S_RMW_RD, S_RMW_WR, S_ST, S_ERR, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misaligned;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic signed [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) m[31:16] = wd[15:0];
        else        m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (misaligned)
            state_d = S_ERR;
          else if (!req_we)
            state_d = S_LD;
          else if (req_size == 2'b10 || (!RMW_ALL && req_addr[1:0] == 2'b00))
            state_d = S_ST;
          else
            state_d = S_RMW_RD;
        end
      end
      S_LD: begin
        rdata_d = load_extract(mem_rdata, size_q, addr_q[1:0], uns_q);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
      S_ST:     state_d = S_RESP;
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory strobes are gated by rst so an aborted access never writes on the reset edge.
  always_comb begin
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_rr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    mem_w_mask = 4'b0000;
    mem_r_mask = 4'b0000;
    if (!rst) begin
      case (state_q)
        S_LD, S_RMW_RD: begin
          mem_ce     = 1'b1;
          mem_rr     = 1'b1;
          mem_r_mask = 4'b1111;
          mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        end
        S_RMW_WR: begin
          mem_ce     = 1'b1;
          mem_we     = 1'b1;
          mem_w_mask = 4'b1111;
          mem_wdata  = merge_q;
          mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        end
        S_ST: begin
          mem_ce     = 1'b1;
          mem_we     = 1'b1;
          mem_wdata  = wdata_q;
          mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
          case (size_q)
            2'b00:   mem_w_mask = 4'b0001;
            2'b01:   mem_w_mask = 4'b0011;
            default: mem_w_mask = 4'b1111;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = !rst && (state_q == S_IDLE);
  assign resp_valid = !rst && (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a word-organised memory model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ce, mem_we, mem_rr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_w_mask, mem_r_mask;

  mem_access_unit #(.ADDR_W(32), .RMW_ALL(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_rr(mem_rr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      for (int l = 0; l < 4; l++)
        if (mem_w_mask[l]) mem[mem_addr[9:2]][8*l +: 8] = mem_wdata[8*l +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int ce_cnt, we_cnt, rr_cnt;
  logic [3:0]  last_wmask, last_rmask;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (mem_ce) ce_cnt++;
    if (mem_we) begin we_cnt++; last_wmask = mem_w_mask; last_wdata = mem_wdata; end
    if (mem_rr) begin rr_cnt++; last_rmask = mem_r_mask; end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat);
    int n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
    end
    ce_cnt = 0; we_cnt = 0; rr_cnt = 0;
    last_wmask = 4'h0; last_rmask = 4'h0; last_wdata = 32'd0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    e.rdata = erd; e.err = eerr; e.acc = cyc; e.lat = elat;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
      sbq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("ready_in_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_ctl", {29'd0, mem_ce, mem_we, mem_rr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // word store then word load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    chk("sw_we_cycles", we_cnt, 1);
    chk("sw_wmask", {28'd0, last_wmask}, 32'hF);
    chk("sw_rr_cycles", rr_cnt, 0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2);
    chk("lw_rr_cycles", rr_cnt, 1);
    chk("lw_rmask", {28'd0, last_rmask}, 32'hF);

    // sub-word load extraction
    mem[8] = 32'h80FF7F01;
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 32'h0000007F, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h22, 32'd0, 32'h000000FF, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h22, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'hFFFF80FF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'h000080FF, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 32'h00007F01, 1'b0, 2);

    // RMW byte store at offset 2
    mem[12] = 32'h11223344;
    issue(1'b1, 2'b00, 1'b0, 32'h32, 32'h000000AB, 32'd0, 1'b0, 3);
    chk("sb_rr_cycles", rr_cnt, 1);
    chk("sb_we_cycles", we_cnt, 1);
    chk("sb_wdata", last_wdata, 32'h11AB3344);
    chk("sb_wmask", {28'd0, last_wmask}, 32'hF);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h11AB3344, 1'b0, 2);

    // RMW halfword store in the upper half
    issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h00005A6B, 32'd0, 1'b0, 3);
    chk("sh_hi_mem", mem[12], 32'h5A6B3344);

    // native halfword store at offset 0
    mem[16] = 32'h12345678;
    issue(1'b1, 2'b01, 1'b0, 32'h40, 32'hCAFEBEEF, 32'd0, 1'b0, 2);
    chk("sh_we_cycles", we_cnt, 1);
    chk("sh_wmask", {28'd0, last_wmask}, 32'h3);
    chk("sh_wdata_lo", {16'd0, last_wdata[15:0]}, 32'h0000BEEF);
    chk("sh_rr_cycles", rr_cnt, 0);
    chk("sh_mem", mem[16], 32'h1234BEEF);

    // misaligned and reserved-size requests
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 2);
    chk("err_lw_ce", ce_cnt, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h15, 32'd0, 32'd0, 1'b1, 2);
    chk("err_lh_ce", ce_cnt, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 32'd0, 1'b1, 2);
    chk("err_sz_ce", ce_cnt, 0);
    chk("err_sz_mem", mem[8], 32'h80FF7F01);

    // reset asserted in the RMW write cycle
    mem[20] = 32'hA5A5A5A5;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h51; req_wdata = 32'h00000011; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rmw_wr", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_gated", {30'd0, mem_ce, mem_we}, 32'd0);
    @(negedge clk);
    chk("abort_outputs", {28'd0, mem_ce, mem_we, mem_rr, resp_valid}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem", mem[20], 32'hA5A5A5A5);
    issue(1'b0, 2'b00, 1'b1, 32'h51, 32'd0, 32'h000000A5, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side load/store unit that sits between the MEM pipeline stage and the word-organised data memory. It accepts one byte, halfword or word access per request and drives the memory's ce/we/memRr/addr/masks. Sub-word loads are aligned and sign- or zero-extended here. Sub-word stores at non-zero byte offsets use a read-modify-write sequence, because the memory's narrow write masks only cover the low lanes of a word.

Parameters:
ADDR_W, 32, width of request and memory address
RMW_ALL, 0, 1 = every sub-word store uses RMW; 0 = offset-0 byte/half stores use native masks 0001/0011

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE and when rst=0
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  load zero-extends when 1
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, low-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned or reserved-size request, valid with resp_valid
mem_ce  out  1  memory chip enable
mem_we  out  1  memory write enable
mem_rr  out  1  memory read enable
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  write data
mem_w_mask  out  4  write mask
mem_r_mask  out  4  read mask, always 1111 when mem_rr=1
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; all mem_* outputs 0; latched request cleared. Reset in any state aborts the access. No memory write is issued on the edge where rst=1.
- Handshake: a request is accepted on the rising edge where req_valid && req_ready. All req_* fields are latched on that edge and are ignored afterwards. One request is outstanding at a time.
- mem_* outputs are registered-state decoded. They are all 0 in every state except LD, RMW_RD, ST and RMW_WR.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> ERR. ERR performs no memory access.
- States and transitions:
  - IDLE: accept. Load -> LD. Word store, or (RMW_ALL=0 and addr[1:0]=0 sub-word store) -> ST. Other sub-word store -> RMW_RD. Misaligned -> ERR.
  - LD: mem_ce=1, mem_rr=1, r_mask=1111. mem_rdata is extracted and latched at the end of the cycle. -> RESP.
  - RMW_RD: as LD. Merged word is latched: store lanes selected by addr[1:0] are replaced with req_wdata low bytes. -> RMW_WR.
  - RMW_WR: mem_ce=1, mem_we=1, w_mask=1111, mem_wdata=merged word. -> RESP.
  - ST: mem_ce=1, mem_we=1, mem_wdata=req_wdata, w_mask=1111 (word) / 0001 (byte) / 0011 (half). -> RESP.
  - ERR: resp_err latched 1. -> RESP.
  - RESP: resp_valid=1 for exactly one cycle. -> IDLE. req_ready is 0 in RESP.
- Latency, counting from the accept edge as cycle 0:
  - load or single store: resp_valid high in cycle 2;
  - RMW store: resp_valid high in cycle 3;
  - error: resp_valid high in cycle 2.
  - Back-to-back: the next accept is possible in the cycle after RESP.
- Load extraction is little-endian:
  - byte = word[8*addr[1:0] +: 8];
  - half = word[16*addr[1] +: 16];
  - sign-extended from the MSB unless req_unsigned=1;
  - a word load returns the word unchanged.
- Store merge: byte at offset k replaces bits [8k+7:8k]. Half at addr[1]=1 replaces [31:16].
- resp_rdata and resp_err hold their values until the next RESP. They are cleared to 0 on accept of a new request.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store: mem_we high 1 cycle with w_mask=1111 and resp in cycle 2; load: resp_rdata=0xDEADBEEF, resp_valid in cycle 2.
- Memory word @0x20 = 0x80FF7F01; loads lb@0x21, lbu@0x22, lh@0x22, lhu@0x22 -> resp_rdata = 0x0000007F, 0x000000FF, 0xFFFF80FF, 0x000080FF.
- Memory word @0x30 = 0x11223344; sb 0xAB @0x32 -> RMW_RD then RMW_WR with mem_wdata=0x11AB3344 and w_mask=1111, resp_valid in cycle 3; a following lw returns 0x11AB3344.
- With RMW_ALL=0, sh 0xBEEF @0x40 -> single ST cycle with w_mask=0011 and mem_wdata low half 0xBEEF; no mem_rr pulse.
- lw @0x13, then lh @0x15, then size=11 -> each gives resp_err=1, resp_rdata=0, no mem_ce, resp_valid in cycle 2.
- Assert rst in the RMW_WR cycle of an sb -> no write occurs; all outputs 0 next cycle; req_ready=1 once rst deasserts; the memory word is unchanged.
